avmm_cmd_master: RTL and testbench

//  Avalon-MM initiator that drains a small command queue onto a register-slave bus
//  (chipselect/write/read/address/writedata/waitrequest/readdata).

---
 rtl/avmm_cmd_master_if.sv | 24 ++
 rtl/avmm_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_avmm_cmd_master.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_cmd_master_if.sv
// Avalon-MM register-slave bus: the command master drives the strobes,
// and the slave answers with waitrequest and readdata.
interface avmm_cmd_master_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avmm_cmd_master.sv
// Avalon-MM initiator: queues read/write commands and plays them onto one
// register-slave port in acceptance order, returning read data as a pulse.
module avmm_cmd_master #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    avmm_cmd_master_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]     q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_write;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push, pop, q_empty;

    logic              cs_q, wr_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              cs_nxt, wr_nxt, rd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [LAT_W-1:0]  lat_cnt_nxt;
    logic              capture;

    // Command queue: ready comes from the registered count, so no bypass path.
    assign q_empty   = (count == '0);
    assign cmd_ready = (count < CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= cmd_addr;
            q_data[wr_ptr]  <= cmd_data;
            q_write[wr_ptr] <= cmd_write;
        end
    end

    // Bus sequencer
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!q_empty) state_nxt = ISSUE;
            ISSUE:   if (!bus.waitrequest) state_nxt = rd_q ? RDWAIT : IDLE;
            RDWAIT:  if (lat_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cs_nxt      = cs_q;
        wr_nxt      = wr_q;
        rd_nxt      = rd_q;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        lat_cnt_nxt = lat_cnt;
        pop         = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                cs_nxt = 1'b0;
                wr_nxt = 1'b0;
                rd_nxt = 1'b0;
                if (!q_empty) begin
                    pop       = 1'b1;
                    cs_nxt    = 1'b1;
                    wr_nxt    = q_write[rd_ptr];
                    rd_nxt    = !q_write[rd_ptr];
                    addr_nxt  = q_addr[rd_ptr];
                    wdata_nxt = q_data[rd_ptr];
                end
            end
            ISSUE: begin
                if (!bus.waitrequest) begin
                    cs_nxt = 1'b0;
                    wr_nxt = 1'b0;
                    rd_nxt = 1'b0;
                    if (rd_q) lat_cnt_nxt = LAT_W'(READ_LATENCY - 1);
                end
            end
            RDWAIT: begin
                if (lat_cnt == '0) capture = 1'b1;
                else               lat_cnt_nxt = lat_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Registered bus and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            cs_q      <= cs_nxt;
            wr_q      <= wr_nxt;
            rd_q      <= rd_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            lat_cnt   <= lat_cnt_nxt;
            rsp_valid <= capture;
            if (capture) rsp_data <= bus.readdata;
        end
    end

    assign bus.chipselect = cs_q;
    assign bus.write      = wr_q;
    assign bus.read       = rd_q;
    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;

    // The response cycle still counts as busy even though the FSM is back in IDLE.
    assign busy = !q_empty || (state != IDLE) || rsp_valid;
endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: a register-file slave model plus command and
// response scoreboards, driven by directed scenarios and random traffic.
module tb_avmm_cmd_master;
    localparam int ADDR_W       = 3;
    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int READ_LATENCY = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    avmm_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avmm_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH), .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                hs;
    } cmd_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                due;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] regs [1 << ADDR_W];
    cmd_t exp_cmd [$];
    rsp_t exp_rsp [$];
    rsp_t rd_pipe [$];

    int outstanding = 0, accepted = 0, started = 0;
    int stall_cnt = 0;
    bit rand_wait = 1'b0;
    int last_hs_cyc = 0, last_start_cyc = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
    int strobe_len = 0, last_len = 0, rsp_count = 0;
    logic              last_acc_w;
    logic [ADDR_W-1:0] last_acc_a;
    logic [DATA_W-1:0] last_acc_d;

    // Slave model and scoreboards, evaluated on the falling edge.
    initial begin
        cmd_t c;
        rsp_t r;
        logic prev_cs, prev_stall, prev_acc, prev_w, prev_r;
        logic [ADDR_W-1:0] prev_a;
        logic [DATA_W-1:0] prev_d, last_rsp;
        prev_cs = 0; prev_stall = 0; prev_acc = 0; prev_w = 0; prev_r = 0;
        prev_a = '0; prev_d = '0; last_rsp = '0;
        bus.waitrequest = 1'b0;
        bus.readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_cmd.delete();
                exp_rsp.delete();
                rd_pipe.delete();
                outstanding = 0; accepted = 0; started = 0;
                prev_cs = 0; prev_stall = 0; prev_acc = 0; last_rsp = '0;
                bus.waitrequest = 1'b0;
                bus.readdata = DATA_W'($urandom);
            end else begin
                if (rd_pipe.size() != 0 && rd_pipe[0].due == cyc) begin
                    bus.readdata = rd_pipe[0].d;
                    void'(rd_pipe.pop_front());
                end else begin
                    bus.readdata = DATA_W'($urandom);
                end

                checks++;
                if (bus.chipselect !== (bus.write | bus.read) || (bus.write & bus.read) !== 1'b0) begin
                    errors++;
                    $display("FAIL strobe_encoding got cs=%b wr=%b rd=%b expected cs = exactly one of wr/rd",
                             bus.chipselect, bus.write, bus.read);
                end
                if (prev_stall) begin
                    checks++;
                    if ({bus.chipselect, bus.write, bus.read, bus.address, bus.writedata} !==
                        {1'b1, prev_w, prev_r, prev_a, prev_d}) begin
                        errors++;
                        $display("FAIL stall_hold got cs=%b wr=%b a=%0d d=%h expected cs=1 wr=%b a=%0d d=%h",
                                 bus.chipselect, bus.write, bus.address, bus.writedata, prev_w, prev_a, prev_d);
                    end
                end
                if (prev_acc) begin
                    checks++;
                    if (bus.chipselect !== 1'b0) begin
                        errors++;
                        $display("FAIL strobe_gap got cs=%b expected 0", bus.chipselect);
                    end
                end

                if (bus.chipselect === 1'b1 && !prev_cs) begin
                    started++;
                    strobe_len = 1;
                    last_start_cyc = cyc;
                    checks++;
                    if (exp_cmd.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected got a=%0d expected no transaction", bus.address);
                    end else begin
                        c = exp_cmd.pop_front();
                        if (c.w !== bus.write || c.a !== bus.address || (c.w && c.d !== bus.writedata)) begin
                            errors++;
                            $display("FAIL issue_order got w=%b a=%0d d=%h expected w=%b a=%0d d=%h",
                                     bus.write, bus.address, bus.writedata, c.w, c.a, c.d);
                        end
                        checks++;
                        if (cyc < c.hs + 2) begin
                            errors++;
                            $display("FAIL issue_early got %0d cycles expected >= 2", cyc - c.hs);
                        end
                    end
                end else if (bus.chipselect === 1'b1) begin
                    strobe_len++;
                end

                checks++;
                if (cmd_ready !== ((accepted - started) < FIFO_DEPTH)) begin
                    errors++;
                    $display("FAIL cmd_ready got %b expected %b (queued %0d)",
                             cmd_ready, (accepted - started) < FIFO_DEPTH, accepted - started);
                end
                checks++;
                if (busy !== (outstanding != 0)) begin
                    errors++;
                    $display("FAIL busy got %b expected %b", busy, outstanding != 0);
                end

                if (rsp_valid === 1'b1) begin
                    checks++;
                    if (exp_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected got data=%h expected no rsp_valid", rsp_data);
                    end else begin
                        r = exp_rsp.pop_front();
                        if (r.due != cyc || rsp_data !== r.d) begin
                            errors++;
                            $display("FAIL rsp_data got %h at cycle %0d expected %h at cycle %0d",
                                     rsp_data, cyc, r.d, r.due);
                        end
                        last_rsp = r.d;
                        outstanding--;
                        rsp_count++;
                        last_rsp_cyc = cyc;
                    end
                end else begin
                    checks++;
                    if (rsp_data !== last_rsp) begin
                        errors++;
                        $display("FAIL rsp_hold got %h expected %h", rsp_data, last_rsp);
                    end
                    if (exp_rsp.size() != 0 && exp_rsp[0].due <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_missing got rsp_valid=0 expected 1 with data %h", exp_rsp[0].d);
                        void'(exp_rsp.pop_front());
                    end
                end

                // Slave response for the coming edge; waitrequest is noise when not selected.
                if (bus.chipselect === 1'b1 && stall_cnt > 0) begin
                    bus.waitrequest = 1'b1;
                    stall_cnt--;
                end else if (rand_wait) begin
                    bus.waitrequest = ($urandom_range(0, 2) == 0);
                end else begin
                    bus.waitrequest = 1'b0;
                end

                prev_acc   = (bus.chipselect === 1'b1) && !bus.waitrequest;
                prev_stall = (bus.chipselect === 1'b1) && bus.waitrequest;
                if (prev_acc) begin
                    last_acc_cyc = cyc;
                    last_len     = strobe_len;
                    last_acc_w   = bus.write;
                    last_acc_a   = bus.address;
                    last_acc_d   = bus.writedata;
                    if (bus.write) begin
                        regs[bus.address] = bus.writedata;
                        outstanding--;
                    end else begin
                        r.d = regs[bus.address];
                        r.due = cyc + READ_LATENCY;
                        rd_pipe.push_back(r);
                        r.due = cyc + READ_LATENCY + 1;
                        exp_rsp.push_back(r);
                    end
                end
                prev_cs = bus.chipselect;
                prev_w  = bus.write;
                prev_r  = bus.read;
                prev_a  = bus.address;
                prev_d  = bus.writedata;

                if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                    c.w = cmd_write; c.a = cmd_addr; c.d = cmd_data; c.hs = cyc;
                    exp_cmd.push_back(c);
                    accepted++;
                    outstanding++;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output int waited);
        waited = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout got cmd_ready=%b expected 1 within 100 cycles", cmd_ready);
        end else begin
            tick();
        end
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_data  = DATA_W'($urandom);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b expected 0 within %0d cycles", busy, max_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.chipselect, bus.write, bus.read} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b expected 000", {bus.chipselect, bus.write, bus.read});
        end
        checks++;
        if ({bus.address, bus.writedata, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%0d wd=%h rsp=%h expected 0", bus.address, bus.writedata, rsp_data);
        end
        checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_status got vld/busy/ready=%b expected 001", {rsp_valid, busy, cmd_ready});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        int w;
        int acc_before = last_acc_cyc;
        push(1'b1, 3'd2, 8'h80, w);
        wait_idle(50);
        checks++;
        if (last_acc_cyc == acc_before || last_acc_w !== 1'b1 || last_acc_a !== 3'd2 || last_acc_d !== 8'h80) begin
            errors++;
            $display("FAIL single_write got w=%b a=%0d d=%h expected w=1 a=2 d=80", last_acc_w, last_acc_a, last_acc_d);
        end
        checks++;
        if (last_len != 1) begin
            errors++;
            $display("FAIL single_write_len got %0d strobe cycles expected 1", last_len);
        end
        checks++;
        if (last_start_cyc - last_hs_cyc != 2) begin
            errors++;
            $display("FAIL single_write_latency got %0d expected 2", last_start_cyc - last_hs_cyc);
        end
    endtask

    task automatic test_stall();
        int w;
        stall_cnt = 3;
        push(1'b1, 3'd1, 8'h5A, w);
        wait_idle(50);
        checks++;
        if (last_len != 4) begin
            errors++;
            $display("FAIL stall_len got %0d strobe cycles expected 4", last_len);
        end
        checks++;
        if (last_acc_a !== 3'd1 || last_acc_d !== 8'h5A || stall_cnt != 0) begin
            errors++;
            $display("FAIL stall_write got a=%0d d=%h expected a=1 d=5a", last_acc_a, last_acc_d);
        end
    endtask

    task automatic test_read();
        int w;
        int rc = rsp_count;
        regs[3] = 8'hC3;
        push(1'b0, 3'd3, 8'h00, w);
        wait_idle(50);
        checks++;
        if (rsp_count - rc != 1) begin
            errors++;
            $display("FAIL read_pulses got %0d expected 1", rsp_count - rc);
        end
        checks++;
        if (rsp_data !== 8'hC3) begin
            errors++;
            $display("FAIL read_data got %h expected c3", rsp_data);
        end
        checks++;
        if (last_rsp_cyc - last_hs_cyc != 3 + READ_LATENCY) begin
            errors++;
            $display("FAIL read_latency got %0d expected %0d", last_rsp_cyc - last_hs_cyc, 3 + READ_LATENCY);
        end
    endtask

    task automatic test_fill();
        int w;
        int n = 0;
        stall_cnt = 40;
        push(1'b1, 3'd0, 8'h11, w);
        while (bus.chipselect !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.chipselect !== 1'b1) begin
            errors++;
            $display("FAIL fill_blocker got cs=%b expected 1", bus.chipselect);
        end
        push(1'b1, 3'd4, 8'hA4, w);
        push(1'b0, 3'd4, 8'h00, w);
        push(1'b1, 3'd5, 8'hB5, w);
        push(1'b1, 3'd7, 8'hC7, w);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready got %b expected 0", cmd_ready);
        end
        push(1'b0, 3'd5, 8'h00, w);
        checks++;
        if (w < 20) begin
            errors++;
            $display("FAIL fill_held got %0d wait cycles expected >= 20", w);
        end
        checks++;
        if (last_hs_cyc != last_start_cyc) begin
            errors++;
            $display("FAIL fill_release got accept cycle %0d expected %0d", last_hs_cyc, last_start_cyc);
        end
        wait_idle(300);
    endtask

    task automatic test_reset_rdwait();
        int w;
        int n = 0;
        int acc_before = last_acc_cyc;
        int rc;
        bit saw;
        push(1'b0, 3'd5, 8'h00, w);
        while (last_acc_cyc == acc_before && n < 20) begin
            tick();
            n++;
        end
        rc = rsp_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.chipselect, bus.write, bus.read, rsp_valid, busy, cmd_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL abort_state got cs/wr/rd/vld/busy/ready=%b expected 000001",
                     {bus.chipselect, bus.write, bus.read, rsp_valid, busy, cmd_ready});
        end
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (rsp_valid !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw || rsp_count != rc) begin
            errors++;
            $display("FAIL abort_rsp got rsp_valid pulse expected none");
        end
        push(1'b1, 3'd6, 8'h3C, w);
        wait_idle(50);
        checks++;
        if (last_acc_w !== 1'b1 || last_acc_a !== 3'd6 || last_acc_d !== 8'h3C) begin
            errors++;
            $display("FAIL abort_next got w=%b a=%0d d=%h expected w=1 a=6 d=3c", last_acc_w, last_acc_a, last_acc_d);
        end
    endtask

    task automatic test_random();
        int w;
        int nrd = 0;
        int rc = rsp_count;
        logic wr;
        rand_wait = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom);
            if (!wr) nrd++;
            push(wr, ADDR_W'($urandom), DATA_W'($urandom), w);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(800);
        rand_wait = 1'b0;
        checks++;
        if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d cmds %0d rsps pending expected 0", exp_cmd.size(), exp_rsp.size());
        end
        checks++;
        if (rsp_count - rc != nrd) begin
            errors++;
            $display("FAIL random_rsp_count got %0d expected %0d", rsp_count - rc, nrd);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) regs[i] = DATA_W'($urandom);
        test_reset();
        test_single_write();
        test_stall();
        test_read();
        test_fill();
        test_reset_rdwait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
